// File: rtl/burst_write_controller.sv
// rtl/burst_write_controller.sv - drains the store burst buffer to the external memory port as write bursts
module burst_write_controller #(
    parameter int BUFFER_DEPTH = 1024,
    parameter int BURST_LENGTH = 16,
    parameter int TIMEOUT      = 256,
    parameter int ADDR_WIDTH   = 32
) (
    input  logic                              clk_i,
    input  logic                              rst_n_i,
    input  logic                              flush_i,
    input  logic                              drain_i,
    input  logic                              base_load_i,
    input  logic [ADDR_WIDTH-1:0]             base_addr_i,
    input  logic [$clog2(BUFFER_DEPTH)-1:0]   buf_size_i,
    input  logic                              buf_valid_i,
    input  logic [31:0]                       buf_data_i,
    output logic                              buf_pull_o,
    output logic                              ext_req_o,
    output logic [ADDR_WIDTH-1:0]             ext_addr_o,
    output logic [$clog2(BURST_LENGTH):0]     ext_len_o,
    input  logic                              ext_grant_i,
    output logic [31:0]                       ext_data_o,
    output logic                              ext_data_valid_o,
    input  logic                              ext_ready_i,
    input  logic                              ext_done_i,
    output logic                              idle_o
);

    localparam int SIZE_W = $clog2(BUFFER_DEPTH);
    localparam int LEN_W  = $clog2(BURST_LENGTH) + 1;
    localparam int TMR_W  = $clog2(TIMEOUT + 1);

    localparam logic [SIZE_W-1:0] BURST_SZ  = SIZE_W'(BURST_LENGTH);
    localparam logic [LEN_W-1:0]  BURST_LEN = LEN_W'(BURST_LENGTH);
    localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQUEST,
        ST_TRANSFER,
        ST_WAIT_DONE
    } state_t;

    state_t                  state;
    logic [TMR_W-1:0]        timer;
    logic [LEN_W-1:0]        len;
    logic [LEN_W-1:0]        remaining;
    logic                    pending;
    logic [ADDR_WIDTH-1:0]   pointer;

    logic                    size_nz;
    logic                    trigger;
    logic [LEN_W-1:0]        burst_len;
    logic                    beat_free;

    assign size_nz   = (buf_size_i != '0);
    assign trigger   = buf_valid_i && size_nz &&
                       ((buf_size_i >= BURST_SZ) || drain_i || (timer == TMR_LAST));
    assign burst_len = (buf_size_i >= BURST_SZ) ? BURST_LEN : LEN_W'(buf_size_i);
    // The output slot is free when nothing is held or the held beat leaves this cycle.
    assign beat_free = !pending || ext_ready_i;

    assign buf_pull_o       = (state == ST_TRANSFER) && (remaining != '0) && size_nz && beat_free;
    assign ext_addr_o       = pointer;
    assign ext_len_o        = len;
    assign ext_data_o       = buf_data_i;
    assign ext_data_valid_o = pending;
    assign idle_o           = (state == ST_IDLE) && !pending;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state     <= ST_IDLE;
            timer     <= '0;
            len       <= '0;
            remaining <= '0;
            pending   <= 1'b0;
            pointer   <= '0;
            ext_req_o <= 1'b0;
        end else if (flush_i) begin
            state     <= ST_IDLE;
            timer     <= '0;
            len       <= '0;
            remaining <= '0;
            pending   <= 1'b0;
            ext_req_o <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // A base load takes the cycle; a coincident trigger is re-evaluated next cycle.
                    if (base_load_i) begin
                        pointer <= base_addr_i;
                    end else if (trigger) begin
                        len       <= burst_len;
                        timer     <= '0;
                        ext_req_o <= 1'b1;
                        state     <= ST_REQUEST;
                    end else if (!size_nz) begin
                        timer <= '0;
                    end else if (timer != TMR_LAST) begin
                        timer <= timer + 1'b1;
                    end
                end
                ST_REQUEST: begin
                    if (ext_grant_i) begin
                        remaining <= len;
                        ext_req_o <= 1'b0;
                        state     <= ST_TRANSFER;
                    end
                end
                ST_TRANSFER: begin
                    if (buf_pull_o) begin
                        remaining <= remaining - 1'b1;
                        pending   <= 1'b1;
                    end else if (ext_ready_i) begin
                        pending <= 1'b0;
                    end
                    if ((remaining == '0) && beat_free) begin
                        state <= ST_WAIT_DONE;
                    end
                end
                ST_WAIT_DONE: begin
                    if (ext_done_i) begin
                        pointer <= pointer + ADDR_WIDTH'({len, 2'b00});
                        state   <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_burst_write_controller.sv
// tb/tb_burst_write_controller.sv - directed and randomized bench with a behavioural burst model
module tb_burst_write_controller;

    localparam int SW = 10;
    localparam int LW = 5;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            flush = 1'b0, drain = 1'b0, base_load = 1'b0;
    logic [31:0]     base_addr = '0;
    logic [SW-1:0]   buf_size;
    logic            buf_valid = 1'b1;
    logic [31:0]     buf_data = '0;
    logic            buf_pull;
    logic            ext_req;
    logic [31:0]     ext_addr;
    logic [LW-1:0]   ext_len;
    logic            ext_grant = 1'b0;
    logic [31:0]     ext_data;
    logic            ext_data_valid;
    logic            ext_ready = 1'b1;
    logic            ext_done = 1'b1;
    logic            idle;

    burst_write_controller dut (
        .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush), .drain_i(drain),
        .base_load_i(base_load), .base_addr_i(base_addr), .buf_size_i(buf_size),
        .buf_valid_i(buf_valid), .buf_data_i(buf_data), .buf_pull_o(buf_pull),
        .ext_req_o(ext_req), .ext_addr_o(ext_addr), .ext_len_o(ext_len),
        .ext_grant_i(ext_grant), .ext_data_o(ext_data), .ext_data_valid_o(ext_data_valid),
        .ext_ready_i(ext_ready), .ext_done_i(ext_done), .idle_o(idle)
    );

    always #5 clk = ~clk;

    // Buffer environment: words are numbered in push order and read back in order.
    int unsigned wr_cnt = 0, rd_cnt = 0, push_n = 0;
    assign buf_size = SW'(wr_cnt - rd_cnt);

    function automatic logic [31:0] word_of(input int unsigned i);
        return (i * 32'h9E37_79B1) ^ 32'hC0FF_EE00;
    endfunction

    always @(posedge clk) begin
        if (buf_pull) begin
            buf_data <= word_of(rd_cnt);
            rd_cnt   <= rd_cnt + 1;
        end
        wr_cnt <= wr_cnt + push_n;
    end

    int total = 0, bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: phase 0 idle, 1 requesting, 2 moving words, 3 awaiting response.
    int          m_phase = 0, m_timer = 0, m_len = 0, m_pulled = 0;
    bit          m_beat = 0;
    logic [31:0] m_ptr = '0;
    int unsigned m_rd = 0;

    function automatic bit model_pull();
        return (m_phase == 2) && (m_pulled < m_len) && (buf_size != 0) && (!m_beat || ext_ready);
    endfunction

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_phase = 0; m_timer = 0; m_len = 0; m_pulled = 0; m_beat = 0; m_ptr = '0;
        end else begin
            bit p;
            int sz;
            p  = model_pull();
            sz = int'(buf_size);
            if (p) m_rd++;
            if (flush) begin
                m_phase = 0; m_timer = 0; m_len = 0; m_pulled = 0; m_beat = 0;
            end else begin
                case (m_phase)
                    0: begin
                        if (base_load) m_ptr = base_addr;
                        else if (buf_valid && sz > 0 && (sz >= 16 || drain || m_timer == 255)) begin
                            m_len = (sz < 16) ? sz : 16;
                            m_timer = 0;
                            m_phase = 1;
                        end else if (sz == 0) m_timer = 0;
                        else if (m_timer < 255) m_timer++;
                    end
                    1: if (ext_grant) begin m_pulled = 0; m_phase = 2; end
                    2: begin
                        if (m_pulled == m_len && (!m_beat || ext_ready)) m_phase = 3;
                        if (p) begin m_pulled++; m_beat = 1; end
                        else if (ext_ready) m_beat = 0;
                    end
                    default: if (ext_done) begin m_ptr = m_ptr + 32'(m_len * 4); m_phase = 0; end
                endcase
            end
        end
    end

    int cyc = 0, pull_cnt = 0, beat_cnt = 0;

    initial forever begin
        @(negedge clk);
        cyc++;
        chk("pull", buf_pull, model_pull());
        chk("req", ext_req, m_phase == 1);
        chk("data_valid", ext_data_valid, m_beat);
        chk("idle", idle, (m_phase == 0) && !m_beat);
        if (m_phase == 1) begin
            chk("addr", ext_addr, m_ptr);
            chk("len", ext_len, m_len);
        end
        if (m_beat) chk("data", ext_data, word_of(m_rd - 1));
        if (buf_pull) pull_cnt++;
        if (ext_data_valid && ext_ready) beat_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input int maxc, output int n);
        n = 0;
        while (!ext_req && n < maxc) begin tick(); n++; end
        if (!ext_req) begin
            total++; bad++;
            $display("FAIL wait_req: no request within %0d cycles", maxc);
        end
    endtask

    task automatic wait_noreq(input int maxc);
        int n = 0;
        while (ext_req && n < maxc) begin tick(); n++; end
        if (ext_req) begin
            total++; bad++;
            $display("FAIL wait_noreq: request still high after %0d cycles", maxc);
        end
    endtask

    task automatic wait_empty(input int maxc);
        int n = 0;
        while (!(idle && buf_size == 0) && n < maxc) begin tick(); n++; end
        if (!(idle && buf_size == 0)) begin
            total++; bad++;
            $display("FAIL wait_empty: not idle/empty after %0d cycles", maxc);
        end
    endtask

    task automatic wait_beats(input int b0, input int want, input int maxc);
        int n = 0;
        while (beat_cnt - b0 < want && n < maxc) begin tick(); n++; end
        if (beat_cnt - b0 < want) begin
            total++; bad++;
            $display("FAIL wait_beats: got %0d beats required %0d", beat_cnt - b0, want);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n, p0, b0, c1, c16;
        logic [LW-1:0] lens [3];
        logic [31:0]   addrs [3];

        repeat (3) tick();
        chk("rst_req", ext_req, 0);
        chk("rst_idle", idle, 1);
        chk("rst_pull", buf_pull, 0);
        chk("rst_valid", ext_data_valid, 0);
        chk("rst_addr", ext_addr, 0);
        rst_n = 1'b1;
        tick();

        // Threshold burst with a two-cycle grant delay.
        for (int i = 0; i < 16; i++) begin push_n = 1; tick(); end
        push_n = 0;
        wait_req(40, n);
        chk("s1_addr", ext_addr, 32'h0);
        chk("s1_len", ext_len, 16);
        p0 = pull_cnt; b0 = beat_cnt; c1 = -1; c16 = -1;
        tick(); tick();
        ext_grant = 1'b1;
        tick();
        ext_grant = 1'b0;
        repeat (40) begin
            tick();
            if (c1 < 0 && pull_cnt - p0 >= 1) c1 = cyc;
            if (c16 < 0 && pull_cnt - p0 >= 16) c16 = cyc;
        end
        chk("s1_pulls", pull_cnt - p0, 16);
        chk("s1_beats", beat_cnt - b0, 16);
        chk("s1_consecutive", c16 - c1, 15);
        ext_grant = 1'b1;

        // Partial burst forced by the idle timer.
        push_n = 3;
        tick();
        push_n = 0;
        wait_req(400, n);
        chk("s2_timeout_cycles", n, 256);
        chk("s2_len", ext_len, 3);
        chk("s2_addr", ext_addr, 32'h40);
        wait_empty(100);

        // Drain of 40 words from base 0.
        base_load = 1'b1; base_addr = 32'h0;
        tick();
        base_load = 1'b0;
        push_n = 40; drain = 1'b1;
        tick();
        push_n = 0;
        for (int i = 0; i < 3; i++) begin
            wait_req(60, n);
            lens[i] = ext_len; addrs[i] = ext_addr;
            wait_noreq(5);
        end
        chk("s3_len0", lens[0], 16);
        chk("s3_len1", lens[1], 16);
        chk("s3_len2", lens[2], 8);
        chk("s3_addr1", addrs[1], 32'h40);
        chk("s3_addr2", addrs[2], 32'h80);
        wait_empty(200);
        drain = 1'b0;
        chk("s3_idle", idle, 1);

        // Sink stall mid-burst.
        push_n = 16;
        tick();
        push_n = 0;
        wait_req(40, n);
        chk("s4_addr", ext_addr, 32'hA0);
        p0 = pull_cnt; b0 = beat_cnt;
        wait_beats(b0, 4, 40);
        ext_ready = 1'b0;
        repeat (3) tick();
        ext_ready = 1'b1;
        wait_empty(100);
        chk("s4_pulls", pull_cnt - p0, 16);
        chk("s4_beats", beat_cnt - b0, 16);

        // Flush after five beats, then restart from the same address.
        push_n = 16;
        tick();
        push_n = 0;
        wait_req(40, n);
        chk("s5_addr", ext_addr, 32'hE0);
        b0 = beat_cnt;
        wait_beats(b0, 5, 40);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("s5_idle", idle, 1);
        chk("s5_req", ext_req, 0);
        chk("s5_valid", ext_data_valid, 0);
        chk("s5_pull", buf_pull, 0);
        drain = 1'b1;
        wait_req(40, n);
        chk("s5_readdr", ext_addr, 32'hE0);
        wait_empty(100);
        drain = 1'b0;

        // Asynchronous reset while requesting.
        ext_grant = 1'b0;
        push_n = 16;
        tick();
        push_n = 0;
        wait_req(40, n);
        tick(); tick();
        #2 rst_n = 1'b0;
        #1;
        chk("s6_req", ext_req, 0);
        chk("s6_idle", idle, 1);
        chk("s6_ptr", ext_addr, 32'h0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        tick();
        ext_grant = 1'b1;
        wait_req(40, n);
        chk("s6_addr", ext_addr, 32'h0);
        chk("s6_len", ext_len, 16);
        wait_empty(100);

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            flush     = ($urandom % 64) == 0;
            base_load = ($urandom % 40) == 0;
            base_addr = $urandom;
            if ($urandom % 50 == 0) drain = ~drain;
            buf_valid = ($urandom % 8) != 0;
            ext_grant = $urandom % 2;
            ext_ready = ($urandom % 4) != 0;
            ext_done  = ($urandom % 3) == 0;
            push_n    = (buf_size < 1000 && $urandom % 5 == 0) ? $urandom_range(1, 6) : 0;
            tick();
        end
        flush = 1'b0; base_load = 1'b0; push_n = 0;
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/burst_write_controller.md
Name: burst_write_controller

Overview:
- Sequences the store burst buffer and drains it to the external memory interface as write bursts.
- Watches buffer occupancy and the all-valid flag, decides when to start a burst, and issues an address/length request.
- Pulls exactly the granted number of words from the buffer and streams them out under a valid/ready handshake.
- Sits between the burst buffer and the external memory bus port.

Parameters:
- BUFFER_DEPTH, 1024: depth of the controlled burst buffer; sets the width of buf_size_i.
- BURST_LENGTH, 16: maximum words per burst and the occupancy threshold that triggers a burst; power of two, at most BUFFER_DEPTH-1.
- TIMEOUT, 256: idle cycles with a non-empty, all-valid buffer before a partial burst is forced.
- ADDR_WIDTH, 32: external byte-address width.

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  asynchronous active-low reset
- flush_i  in  1  pipeline flush; aborts the current burst
- drain_i  in  1  force drain of all valid entries (fence)
- base_load_i  in  1  load base_addr_i into the address pointer
- base_addr_i  in  ADDR_WIDTH  new destination base byte address
- buf_size_i  in  $clog2(BUFFER_DEPTH)  buffer occupancy
- buf_valid_i  in  1  all buffered entries validated
- buf_data_i  in  32  buffer read data, registered one cycle after a pull
- buf_pull_o  out  1  pull strobe to the buffer
- ext_req_o  out  1  burst request
- ext_addr_o  out  ADDR_WIDTH  burst start byte address
- ext_len_o  out  $clog2(BURST_LENGTH)+1  burst word count
- ext_grant_i  in  1  request accepted
- ext_data_o  out  32  write data
- ext_data_valid_o  out  1  write data valid
- ext_ready_i  in  1  sink accepts the data beat
- ext_done_i  in  1  burst write response
- idle_o  out  1  FSM is in IDLE with no pending beat

Behaviour:
- Reset (async, rst_n_i low):
  - state=IDLE; timer, remaining, pending and the address pointer all cleared.
  - All outputs 0 except idle_o=1.
- FSM states: IDLE, REQUEST, TRANSFER, WAIT_DONE.
- IDLE, trigger condition: buf_valid_i && buf_size_i!=0 && (buf_size_i>=BURST_LENGTH || drain_i || timer==TIMEOUT-1).
  - On trigger: capture len=min(buf_size_i, BURST_LENGTH), clear timer, go to REQUEST.
- IDLE, timer: increments while buf_size_i!=0 and there is no trigger; clears when buf_size_i==0.
- REQUEST:
  - ext_req_o=1; ext_addr_o=pointer and ext_len_o=len, both held stable until grant.
  - On ext_grant_i: remaining<=len, go to TRANSFER.
- TRANSFER:
  - buf_pull_o = (remaining!=0) && (!pending || ext_ready_i).
  - Each pull decrements remaining.
  - pending <= buf_pull_o ? 1 : (ext_ready_i ? 0 : pending).
  - ext_data_valid_o=pending; ext_data_o=buf_data_i. Data is stable under stall because the buffer does not update without a pull.
  - When remaining==0 and (!pending || ext_ready_i): go to WAIT_DONE.
- WAIT_DONE:
  - On ext_done_i: pointer <= pointer + (len<<2), modulo 2^ADDR_WIDTH; go to IDLE.
- Data throughput: one beat per cycle with ext_ready_i held high. First data beat appears 1 cycle after the first pull.
- Never pulls more than len words per burst. Never pulls when buf_size_i==0.
- flush_i (synchronous, priority over everything except reset):
  - Next cycle: state=IDLE; timer, remaining and pending cleared; all strobes low.
  - Pointer is kept; len is discarded.
- base_load_i:
  - Honoured only in IDLE; ignored in any other state.
  - Simultaneous with a trigger: the load wins and the trigger is deferred one cycle.
- drain_i: level-sensitive. While held, bursts repeat until buf_size_i==0.
- idle_o = (state==IDLE) && !pending.

Test Plan:
- Size rises to 16 with buf_valid_i=1, grant after 2 cycles, ext_ready_i=1 -> ext_req_o with addr 0x0 and len 16; 16 pulls on consecutive cycles; 16 beats; after ext_done_i, pointer=0x40.
- Size=3, valid, no drain -> request issued exactly 256 cycles later with len 3; pointer advances by 12 after done.
- Size=40, drain_i held -> bursts of 16, 16 and 8 words; final pointer 0xA0; idle_o=1 once size reaches 0.
- ext_ready_i low for 3 cycles in mid-burst -> buf_pull_o low during the stall; ext_data_o holds its value; no beat lost or duplicated; total beats = len.
- flush_i in TRANSFER after 5 beats -> next cycle IDLE with all strobes 0; pointer unchanged; a new burst then starts from the same address.
- Assert rst_n_i low asynchronously mid-REQUEST -> ext_req_o drops immediately; pointer=0; idle_o=1.
